hazard_control: RTL and testbench
=================================

# hazard_control

Pipeline sequencing controller for the five-stage MIPS core. It sits beside the forwarding unit and resolves the hazards that forwarding cannot fix: load-use dependencies, taken-branch flushes, and data-memory wait states. It drives the PC and pipeline-register write enables, flush and bubble controls. It also keeps saturating stall and flush performance counters and a sticky memory-timeout error flag.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters
- MEM_TIMEOUT, 64, maximum number of MEM_WAIT cycles before the error flag is raised

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high
- IDEX_MemRead  input  1  the instruction in EX is a load
- IDEX_RegisterRt  input  5  destination of the load in EX
- IFID_RegisterRs  input  5  rs of the instruction in ID
- IFID_RegisterRt  input  5  rt of the instruction in ID
- branch_taken  input  1  taken branch or jump resolved in EX this cycle
- EXMem_MemAccess  input  1  the instruction in MEM performs a load or store
- dmem_ready  input  1  data memory completes the access this cycle
- pc_write  output  1  PC update enable
- IFID_write  output  1  IF/ID register write enable
- IFID_flush  output  1  IF/ID loads a NOP
- IDEX_bubble  output  1  ID/EX loads a NOP (control bits zeroed)
- pipe_hold  output  1  EX/MEM and MEM/WB hold their contents
- stall_cycles  output  CNT_W  number of cycles with pc_write low
- flush_events  output  CNT_W  number of taken-branch flushes
- mem_error  output  1  sticky memory-timeout flag

## Operation
States:
- RUN: normal operation.
- MEM_WAIT: the pipeline is frozen waiting for memory.

Control outputs are combinational from the current state and inputs.

Hazard terms:
- load_use = IDEX_MemRead && IDEX_RegisterRt != 0 && (IDEX_RegisterRt == IFID_RegisterRs || IDEX_RegisterRt == IFID_RegisterRt).
- mem_stall = EXMem_MemAccess && !dmem_ready.

Hazards are resolved in fixed priority order.

1. mem_stall, in either state:
   - outputs: pc_write=0, IFID_write=0, pipe_hold=1, IDEX_bubble=0, IFID_flush=0; the whole pipeline freezes.
   - next state is MEM_WAIT.
2. branch_taken, no mem_stall, state RUN:
   - outputs: IFID_flush=1, IDEX_bubble=1, pc_write=1 (the PC loads the branch target), IFID_write=1.
   - flush_events increments.
3. load_use, with no higher-priority hazard:
   - outputs: pc_write=0, IFID_write=0, IDEX_bubble=1.
   - This is a one-cycle stall. The next cycle the load is in MEM, so load_use clears naturally.
4. No hazard: pc_write=1, IFID_write=1, all other controls 0.

MEM_WAIT behaviour:
- Leaves to RUN in the cycle dmem_ready=1. In that cycle the outputs follow the RUN rules, so a branch or load-use hazard present in that cycle is serviced immediately.
- A wait counter increments each MEM_WAIT cycle and is cleared on entry to RUN.
- When the counter reaches MEM_TIMEOUT-1 while still waiting, mem_error sets and stays set until reset. The freeze continues regardless; the error flag never forces an exit.

Counters:
- stall_cycles increments every cycle with pc_write=0.
- Both counters saturate at all-ones and never wrap.

## Timing
- Reset values: state RUN; wait counter 0; stall_cycles 0; flush_events 0; mem_error 0.
- While reset is high the combinational outputs still follow the RUN equations. Callers gate pipeline registers with reset.
- Reset asserted mid-MEM_WAIT takes effect at the next edge; the wait is abandoned and the counters clear.
- Latency from hazard inputs to control outputs is zero cycles (same-cycle combinational). Counters and mem_error update one edge later.
- Simultaneous branch_taken and load_use: branch wins. The ID instruction is flushed, so no stall is needed.
- Simultaneous mem_stall and branch_taken: the freeze wins and the branch is re-evaluated when the pipeline resumes. Because the EX stage is held, branch_taken stays asserted. flush_events counts the branch once, on the servicing cycle.
- dmem_ready=1 in the same cycle EXMem_MemAccess rises: no stall and no state change.
- A load to $0 never stalls.

## Structure
- The shared package holds:
  - the state encoding: RUN=1'b0, MEM_WAIT=1'b1;
  - the NOP and bubble constant used by the pipeline registers;
  - the register-zero constant 5'd0.
- One natural sub-module is sat_counter (parameter W; inputs clk, reset, inc; output count), instantiated twice.
- The FSM and hazard logic stay in hazard_control.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_RegisterRt=5, IFID_RegisterRs=5 for one cycle -> pc_write=0, IFID_write=0, IDEX_bubble=1; stall_cycles goes 0→1.
- Load to $0: IDEX_RegisterRt=0, IFID_RegisterRt=0 -> no stall; pc_write=1.
- Branch plus load-use in the same cycle -> IFID_flush=1, IDEX_bubble=1, pc_write=1; flush_events=1; stall_cycles=0.
- Memory wait: EXMem_MemAccess=1, dmem_ready=0 for 3 cycles then 1 -> pipe_hold=1 for exactly 3 cycles; state returns to RUN on the 4th cycle; stall_cycles=3.
- Timeout with MEM_TIMEOUT=4: dmem_ready held at 0 for 6 cycles -> mem_error rises after the 4th MEM_WAIT cycle and stays 1 after dmem_ready=1. Asserting reset clears mem_error, both counters and the state.
- Saturation with CNT_W=4: 20 consecutive load-use stalls -> stall_cycles=15 and holds there.

Source files
------------

// File: rtl/hazard_control_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
package hazard_control_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  // sll $0,$0,0 is the canonical NOP; bubbles carry it with all control bits cleared
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/hazard_control_if.sv
// Hazard inputs from the pipeline stages and the sequencing controls returned to them.
interface hazard_control_if;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_RegisterRt;
  logic [4:0] IFID_RegisterRs;
  logic [4:0] IFID_RegisterRt;
  logic       branch_taken;
  logic       EXMem_MemAccess;
  logic       dmem_ready;
  logic       pc_write;
  logic       IFID_write;
  logic       IFID_flush;
  logic       IDEX_bubble;
  logic       pipe_hold;

  modport master (
    output IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
           branch_taken, EXMem_MemAccess, dmem_ready,
    input  pc_write, IFID_write, IFID_flush, IDEX_bubble, pipe_hold
  );

  modport slave (
    input  IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
           branch_taken, EXMem_MemAccess, dmem_ready,
    output pc_write, IFID_write, IFID_flush, IDEX_bubble, pipe_hold
  );
endinterface

// File: rtl/hazard_control_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_control.sv
// Resolves load-use, taken-branch and memory-wait hazards for the five-stage pipeline.
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  hazard_control_if.slave  hz,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_error
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t   state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic load_use, mem_stall;
  logic pc_write, IFID_write, IFID_flush, IDEX_bubble, pipe_hold;

  assign load_use  = hz.IDEX_MemRead && (hz.IDEX_RegisterRt != REG_ZERO) &&
                     ((hz.IDEX_RegisterRt == hz.IFID_RegisterRs) ||
                      (hz.IDEX_RegisterRt == hz.IFID_RegisterRt));
  assign mem_stall = hz.EXMem_MemAccess && !hz.dmem_ready;

  always_ff @(posedge clk) begin
    if (reset)
      state <= RUN;
    else
      state <= next_state;
  end

  // Without a memory stall both states use the RUN rules, so MEM_WAIT only shapes the wait counter.
  always_comb begin
    next_state  = RUN;
    pc_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (mem_stall) begin
      next_state = MEM_WAIT;
      pc_write   = 1'b0;
      IFID_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (hz.branch_taken) begin
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.IFID_write  = IFID_write;
  assign hz.IFID_flush  = IFID_flush;
  assign hz.IDEX_bubble = IDEX_bubble;
  assign hz.pipe_hold   = pipe_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else if (next_state == RUN) begin
      wait_cnt  <= '0;
    end else if (state == MEM_WAIT) begin
      if (wait_cnt == WAIT_LAST)
        mem_error <= 1'b1;
      else
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (IFID_flush),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_control.sv
// Directed checks of hazard_control built with 4-bit counters and a 4-cycle memory timeout.
module tb_hazard_control;

  localparam int CNT_W = 4;
  localparam int MEM_TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic mem_error;
  int checks = 0;
  int errors = 0;

  hazard_control_if hz();

  hazard_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .hz           (hz),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .mem_error    (mem_error)
  );

  always #5 clk = ~clk;

  // {pc_write, IFID_write, IFID_flush, IDEX_bubble, pipe_hold}
  function automatic logic [4:0] ctrl();
    return {hz.pc_write, hz.IFID_write, hz.IFID_flush, hz.IDEX_bubble, hz.pipe_hold};
  endfunction

  task automatic idle_inputs();
    hz.IDEX_MemRead    = 1'b0;
    hz.IDEX_RegisterRt = 5'd0;
    hz.IFID_RegisterRs = 5'd0;
    hz.IFID_RegisterRt = 5'd0;
    hz.branch_taken    = 1'b0;
    hz.EXMem_MemAccess = 1'b0;
    hz.dmem_ready      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ctrl() !== 5'b11000) begin
      errors++; $display("FAIL reset_ctrl got %b want %b", ctrl(), 5'b11000);
    end
    checks++;
    if ({stall_cycles, flush_events, mem_error} !== '0) begin
      errors++; $display("FAIL reset_state got stall=%0d flush=%0d err=%b want 0 0 0",
                         stall_cycles, flush_events, mem_error);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    hz.IDEX_MemRead = 1'b1; hz.IDEX_RegisterRt = 5'd5;
    hz.IFID_RegisterRs = 5'd5; hz.IFID_RegisterRt = 5'd7;
    #1;
    checks++;
    if (ctrl() !== 5'b00010) begin
      errors++; $display("FAIL load_use_rs got %b want %b", ctrl(), 5'b00010);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (stall_cycles !== 4'd1 || ctrl() !== 5'b11000) begin
      errors++; $display("FAIL load_use_after got stall=%0d ctrl=%b want 1 11000", stall_cycles, ctrl());
    end
    hz.IDEX_MemRead = 1'b1; hz.IDEX_RegisterRt = 5'd9;
    hz.IFID_RegisterRs = 5'd3; hz.IFID_RegisterRt = 5'd9;
    #1;
    checks++;
    if (ctrl() !== 5'b00010) begin
      errors++; $display("FAIL load_use_rt got %b want %b", ctrl(), 5'b00010);
    end
    @(negedge clk);
    hz.IFID_RegisterRt = 5'd10;
    #1;
    checks++;
    if (ctrl() !== 5'b11000 || stall_cycles !== 4'd2) begin
      errors++; $display("FAIL no_match got ctrl=%b stall=%0d want 11000 2", ctrl(), stall_cycles);
    end
    @(negedge clk);
  endtask

  task automatic test_load_zero();
    do_reset();
    hz.IDEX_MemRead = 1'b1; hz.IDEX_RegisterRt = 5'd0;
    hz.IFID_RegisterRs = 5'd0; hz.IFID_RegisterRt = 5'd0;
    #1;
    checks++;
    if (ctrl() !== 5'b11000) begin
      errors++; $display("FAIL load_zero got %b want %b", ctrl(), 5'b11000);
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (stall_cycles !== 4'd0) begin
      errors++; $display("FAIL load_zero_cnt got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_branch_load_use();
    do_reset();
    hz.branch_taken = 1'b1;
    hz.IDEX_MemRead = 1'b1; hz.IDEX_RegisterRt = 5'd4; hz.IFID_RegisterRs = 5'd4;
    #1;
    checks++;
    if (ctrl() !== 5'b11110) begin
      errors++; $display("FAIL branch_lu got %b want %b", ctrl(), 5'b11110);
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (flush_events !== 4'd1 || stall_cycles !== 4'd0) begin
      errors++; $display("FAIL branch_lu_cnt got flush=%0d stall=%0d want 1 0", flush_events, stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    hz.EXMem_MemAccess = 1'b1; hz.dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ctrl() !== 5'b00001) begin
        errors++; $display("FAIL mem_wait_hold cyc %0d got %b want %b", c, ctrl(), 5'b00001);
      end
      @(negedge clk);
    end
    hz.dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctrl() !== 5'b11000) begin
      errors++; $display("FAIL mem_wait_release got %b want %b", ctrl(), 5'b11000);
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (stall_cycles !== 4'd3 || mem_error !== 1'b0) begin
      errors++; $display("FAIL mem_wait_cnt got stall=%0d err=%b want 3 0", stall_cycles, mem_error);
    end
  endtask

  task automatic test_mem_branch();
    do_reset();
    hz.EXMem_MemAccess = 1'b1; hz.dmem_ready = 1'b0; hz.branch_taken = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (ctrl() !== 5'b00001) begin
        errors++; $display("FAIL mem_branch_hold cyc %0d got %b want %b", c, ctrl(), 5'b00001);
      end
      @(negedge clk);
    end
    hz.dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctrl() !== 5'b11110) begin
      errors++; $display("FAIL mem_branch_service got %b want %b", ctrl(), 5'b11110);
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (flush_events !== 4'd1 || stall_cycles !== 4'd2) begin
      errors++; $display("FAIL mem_branch_cnt got flush=%0d stall=%0d want 1 2", flush_events, stall_cycles);
    end
  endtask

  task automatic test_ready_same_cycle();
    do_reset();
    hz.EXMem_MemAccess = 1'b1; hz.dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctrl() !== 5'b11000) begin
      errors++; $display("FAIL ready_same got %b want %b", ctrl(), 5'b11000);
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (stall_cycles !== 4'd0) begin
      errors++; $display("FAIL ready_same_cnt got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    hz.EXMem_MemAccess = 1'b1; hz.dmem_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (mem_error !== (c >= 5)) begin
        errors++; $display("FAIL timeout_flag after %0d edges got %b want %b", c, mem_error, (c >= 5));
      end
    end
    hz.dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctrl() !== 5'b11000) begin
      errors++; $display("FAIL timeout_release got %b want %b", ctrl(), 5'b11000);
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (mem_error !== 1'b1 || stall_cycles !== 4'd6) begin
      errors++; $display("FAIL timeout_sticky got err=%b stall=%0d want 1 6", mem_error, stall_cycles);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({mem_error, stall_cycles, flush_events} !== '0) begin
      errors++; $display("FAIL timeout_reset got err=%b stall=%0d flush=%0d want 0 0 0",
                         mem_error, stall_cycles, flush_events);
    end
    // Reset in the middle of a wait must discard the partial wait count.
    hz.EXMem_MemAccess = 1'b1; hz.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_error !== 1'b0) begin
        errors++; $display("FAIL midwait_reset after %0d edges got %b want 0", c, mem_error);
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_saturation();
    do_reset();
    hz.IDEX_MemRead = 1'b1; hz.IDEX_RegisterRt = 5'd12; hz.IFID_RegisterRs = 5'd12;
    repeat (14) @(negedge clk);
    checks++;
    if (stall_cycles !== 4'd14) begin
      errors++; $display("FAIL sat_14 got %0d want 14", stall_cycles);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (stall_cycles !== 4'd15) begin
      errors++; $display("FAIL sat_20 got %0d want 15", stall_cycles);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (stall_cycles !== 4'd15) begin
      errors++; $display("FAIL sat_hold got %0d want 15", stall_cycles);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_load_zero();
    test_branch_load_use();
    test_mem_wait();
    test_mem_branch();
    test_ready_same_cycle();
    test_timeout();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
